// File: rtl/fifo_drain_pkg.sv
// ---------------------------------------------------------------------------
// fifo_drain_pkg
// Shared types and constants for the fifo_drain pop-side adapter.
//   occ_t      : occupancy of the skid buffer (0..2 words)
//   SKID_DEPTH : number of skid buffer entries
//   tail_idx() : slot that receives the next arriving word
// Optional feature macro used by fifo_drain: FIFO_DRAIN_STATS_EN
// ---------------------------------------------------------------------------
package fifo_drain_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  // With two slots, head+occ (mod 2) reduces to an XOR with the occupancy LSB.
  function automatic logic tail_idx(input logic head, input occ_t occ);
    return head ^ occ[0];
  endfunction

endpackage

// File: rtl/fifo_drain_buf.sv
// ---------------------------------------------------------------------------
// fifo_drain_buf
// Two-entry skid register file with a head pointer.
// Ports:
//   clk      in   clock
//   rstn     in   asynchronous active-low reset (slots and head cleared)
//   wr_en    in   write wr_data into the tail slot (head + occ mod 2)
//   wr_data  in   WIDTH  word to store
//   occ      in   current occupancy, used to locate the tail slot
//   adv      in   consume the head word (head pointer toggles)
//   rd_data  out  WIDTH  word at the head slot
// ---------------------------------------------------------------------------
module fifo_drain_buf
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  occ_t             occ,
  input  logic             adv,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] slot_reg [SKID_DEPTH];
  logic             head_reg;
  logic             tail;

  assign tail = tail_idx(head_reg, occ);

  // Slots reset to zero so the idle head reads back as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        slot_reg[i] <= '0;
      end
    end else if (wr_en) begin
      slot_reg[tail] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_reg <= 1'b0;
    end else if (adv) begin
      head_reg <= ~head_reg;
    end
  end

  assign rd_data = slot_reg[head_reg];

endmodule

// File: rtl/fifo_drain.sv
// ---------------------------------------------------------------------------
// fifo_drain
// Pop-side adapter for a synchronous FIFO with one-cycle read latency.
// Issues FIFO pops and turns the returned words into a valid/ready stream
// through a two-entry skid buffer; sustains one word per cycle.
// Ports:
//   clk         in   clock, all state on posedge
//   rstn        in   asynchronous active-low reset
//   fifo_empty  in   FIFO empty flag
//   fifo_rd     in   WIDTH  FIFO read data, valid the cycle after a pop
//   fifo_pop    out  pop request to the FIFO
//   m_valid     out  output word valid
//   m_ready     in   downstream accepts word
//   m_data      out  WIDTH  output word (head of skid buffer)
//   pop_count   out  CNT_W  pops issued (only with FIFO_DRAIN_STATS_EN)
// Optional feature: define FIFO_DRAIN_STATS_EN to add the pop_count port.
// ---------------------------------------------------------------------------
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd,
  output logic             fifo_pop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [CNT_W-1:0] pop_count
`endif
);

  occ_t       occ_reg;
  occ_t       occ_next;
  logic       infl_reg;
  logic       fire;
  logic [2:0] level_after;

  assign m_valid = (occ_reg != 2'd0);
  assign fire    = m_valid & m_ready;

  // Words held after this edge if no new pop were issued. Never negative:
  // fire implies occ_reg >= 1.
  assign level_after = {1'b0, occ_reg} + {2'b00, infl_reg} - {2'b00, fire};

  // A pop is only issued when its word is guaranteed a free slot on arrival.
  assign fifo_pop = rstn & ~fifo_empty & (level_after < 3'd2);
  assign occ_next = level_after[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_reg  <= '0;
      infl_reg <= 1'b0;
    end else begin
      occ_reg  <= occ_next;
      infl_reg <= fifo_pop;
    end
  end

  // The arriving word is written at tail = head + occ, using occupancy
  // before this edge; a simultaneous fire only moves the head.
  fifo_drain_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (infl_reg),
    .wr_data (fifo_rd),
    .occ     (occ_reg),
    .adv     (fire),
    .rd_data (m_data)
  );

`ifdef FIFO_DRAIN_STATS_EN
  logic [CNT_W-1:0] pop_count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pop_count_reg <= '0;
    end else if (fifo_pop) begin
      pop_count_reg <= pop_count_reg + 1'b1;
    end
  end

  assign pop_count = pop_count_reg;
`else
  // Counter width is only meaningful when statistics are built in.
  if (CNT_W > 0) begin : g_cnt_w_unused
  end
`endif

`ifndef SYNTHESIS
  a_occ_bound : assert property (@(posedge clk) disable iff (!rstn)
    ({1'b0, occ_reg} + {2'b00, infl_reg}) <= 3'd2);
  a_no_underflow : assert property (@(posedge clk) disable iff (!rstn)
    !(fifo_pop && fifo_empty));
`endif

endmodule

// File: tb/tb_fifo_drain.sv
module tb_fifo_drain;

  logic       clk;
  logic       rstn;
  logic       fifo_empty;
  logic [7:0] fifo_rd;
  logic       fifo_pop;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] pop_count;
`endif

  // bench-side FIFO (DEPTH 16, WIDTH 8, registered read)
  logic       push;
  logic [7:0] wd;
  logic [7:0] fmem [16];
  logic [3:0] fw;
  logic [3:0] fr;
  logic [4:0] fcnt;
  logic       do_push;
  logic       do_pop;

  int vectors     = 0;
  int miscompares = 0;
  int pops_total  = 0;
  int fires_total = 0;
  logic [7:0] exp_q [$];

  fifo_drain #(.WIDTH(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_pop   (fifo_pop),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .pop_count  (pop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (fcnt == 5'd0);
  assign do_push    = push && (fcnt != 5'd16);
  assign do_pop     = fifo_pop && (fcnt != 5'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fw      <= '0;
      fr      <= '0;
      fcnt    <= '0;
      fifo_rd <= '0;
    end else begin
      if (do_push) begin
        fmem[fw] <= wd;
        fw       <= fw + 4'd1;
      end
      if (do_pop) begin
        fifo_rd <= fmem[fr];
        fr      <= fr + 4'd1;
      end
      fcnt <= fcnt + {4'd0, do_push} - {4'd0, do_pop};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected words on every fire, checks hold-during-stall
  // and that no pop is ever issued against an empty FIFO.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (fifo_pop && fifo_empty) check("underflow_pop", 1, 0);
        if (prev_stall) begin
          check("stall_valid", {31'd0, m_valid}, 1);
          check("stall_data", {24'd0, m_data}, {24'd0, prev_data});
        end
        if (fifo_pop) pops_total++;
        if (m_valid && m_ready) begin
          fires_total++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            $display("word out 0x%02h expected 0x%02h", m_data, e);
            check("data", {24'd0, m_data}, {24'd0, e});
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    push = 1'b1;
    wd   = d;
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_counts();
    pops_total  = 0;
    fires_total = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    rstn    = 1'b0;
    push    = 1'b0;
    wd      = '0;
    m_ready = 1'b0;

    // 1: reset
    #3;
    check("rst_valid_during", {31'd0, m_valid}, 0);
    check("rst_pop_during", {31'd0, fifo_pop}, 0);
`ifdef FIFO_DRAIN_STATS_EN
    check("rst_pop_count", {16'd0, pop_count}, 0);
`endif
    #18 rstn = 1'b1;
    @(negedge clk);
    check("rst_valid_after", {31'd0, m_valid}, 0);
    check("rst_pop_after", {31'd0, fifo_pop}, 0);
    check("rst_data_after", {24'd0, m_data}, 0);

    // 2: full-rate streaming, latency and throughput
    clear_counts();
    m_ready = 1'b1;
    sync();
    fork
      for (int i = 0; i < 16; i++) push_word(8'(i));
      begin
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
          @(negedge clk);
          if (fifo_pop) found = 1;
        end
        check("first_pop_seen", found, 1);
        // pop sampled at next edge; word arrives the cycle after, then registered
        @(negedge clk);
        check("lat_inflight", {31'd0, m_valid}, 0);
        @(negedge clk);
        check("lat_first_valid", {31'd0, m_valid}, 1);
        for (int i = 1; i < 16; i++) begin
          @(negedge clk);
          check("throughput", {31'd0, m_valid}, 1);
        end
      end
    join
    wait_drain("drain_s2");
    check("s2_pops", pops_total, 16);
`ifdef FIFO_DRAIN_STATS_EN
    check("s2_pop_count", {16'd0, pop_count}, 16);
`endif

    // 3: full backpressure, then release
    clear_counts();
    m_ready = 1'b0;
    sync();
    for (int i = 0; i < 16; i++) push_word(8'(i));
    repeat (3) @(negedge clk);
    check("s3_pops_held", pops_total, 2);
    check("s3_valid_held", {31'd0, m_valid}, 1);
    check("s3_data_held", {24'd0, m_data}, 0);
    sync();
    m_ready = 1'b1;
    wait_drain("drain_s3");
    check("s3_pops_total", pops_total, 16);

    // 4: alternating ready
    clear_counts();
    m_ready = 1'b0;
    sync();
    for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
    for (int i = 0; i < 24; i++) begin
      m_ready = (i % 2 == 0);
      @(negedge clk);
      check("s4_outstanding_le2", {31'd0, (pops_total - fires_total) <= 2}, 1);
      sync();
    end
    m_ready = 1'b1;
    wait_drain("drain_s4");
    check("s4_fires", fires_total, 8);

    // 5: FIFO runs empty mid-stream
    clear_counts();
    m_ready = 1'b1;
    sync();
    for (int i = 0; i < 3; i++) push_word(8'h30 + 8'(i));
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("s5_gap_no_pop", {31'd0, fifo_pop}, 0);
    end
    sync();
    for (int i = 0; i < 3; i++) push_word(8'h40 + 8'(i));
    wait_drain("drain_s5");
    check("s5_fires", fires_total, 6);

    // 6: reset with one word buffered and one in flight
    clear_counts();
    m_ready = 1'b0;
    sync();
    push_word(8'hE0);
    push_word(8'hE1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (m_valid) found = 1;
    end
    check("s6_valid_before_rst", found, 1);
    #2 rstn = 1'b0;
    #1;
    check("s6_valid_async_rst", {31'd0, m_valid}, 0);
    check("s6_pop_async_rst", {31'd0, fifo_pop}, 0);
    exp_q.delete();
    @(negedge clk);
    #2 rstn = 1'b1;
    clear_counts();
    @(negedge clk);
    check("s6_valid_after_rst", {31'd0, m_valid}, 0);
    m_ready = 1'b1;
    sync();
    push_word(8'h55);
    push_word(8'h66);
    push_word(8'h77);
    wait_drain("drain_s6");
    check("s6_fires", fires_total, 3);
    check("s6_idle_valid", {31'd0, m_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
